// File: rtl/rs_stream_ingress_pkg.sv
// Shared types for the bank-to-RS streaming link and the RS-side ingress buffer.
package rs_stream_ingress_pkg;

  localparam int FV_size = 16;

  typedef struct packed {
    logic                    sos;
    logic                    eos;
    logic [1:0][FV_size-1:0] FV_data;
  } Bank2RS;

  typedef struct packed {
    logic                    sos;
    logic                    eos;
    logic [1:0][FV_size-1:0] FV_data;
  } RS_Ingress_Beat;

  localparam int BEAT_W = $bits(RS_Ingress_Beat);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_DISCARD = 2'd2
  } ingress_state_e;

endpackage

// File: rtl/rs_stream_ingress_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full succeeds only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rs_stream_ingress.sv
// RS-side endpoint of the bank-to-RS link: framing checks, beat buffering and RS_available credit.
// Handshake: a head beat transfers on any cycle where out_valid & out_ready; out_* hold otherwise.
module rs_stream_ingress
  import rs_stream_ingress_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int MAX_BEATS = 8,
  parameter int CNT_W     = 16,
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  Bank2RS                  rs_pkt_in,
  output logic                    RS_available,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sos,
  output logic                    out_eos,
  output logic [1:0][FV_size-1:0] out_data,
  output logic [CW-1:0]           beats_stored,
  output logic [CNT_W-1:0]        pkt_rcvd,
  output logic                    protocol_err,
  output ingress_state_e          dbg_state_o
);

  localparam int BW = $clog2(MAX_BEATS + 1);

  ingress_state_e  state_q, state_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] pkt_rcvd_q;
  logic            err_q;

  RS_Ingress_Beat  push_beat, head_beat;
  logic            push, pop, pkt_done, frame_err;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;

  always_comb begin
    state_d           = state_q;
    beat_cnt_d        = beat_cnt_q;
    push              = 1'b0;
    pkt_done          = 1'b0;
    frame_err         = 1'b0;
    push_beat.sos     = 1'b0;
    push_beat.eos     = rs_pkt_in.eos;
    push_beat.FV_data = rs_pkt_in.FV_data;
    case (state_q)
      ST_IDLE: begin
        if (rs_pkt_in.sos) begin
          push          = 1'b1;
          push_beat.sos = 1'b1;
          if (rs_pkt_in.eos) begin
            pkt_done = 1'b1;
          end else begin
            state_d    = ST_RECV;
            beat_cnt_d = BW'(1);
          end
        end else if (rs_pkt_in.eos) begin
          frame_err = 1'b1;
        end
      end
      ST_RECV: begin
        push = 1'b1;
        if (rs_pkt_in.sos) frame_err = 1'b1;
        if (rs_pkt_in.eos) begin
          pkt_done = 1'b1;
          state_d  = ST_IDLE;
        end else if (beat_cnt_q == BW'(MAX_BEATS - 1)) begin
          // Close the stored packet so the RS core still sees a terminated frame.
          push_beat.eos = 1'b1;
          frame_err     = 1'b1;
          state_d       = ST_DISCARD;
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      ST_DISCARD: begin
        if (rs_pkt_in.eos) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      pkt_rcvd_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      if (pkt_done && (pkt_rcvd_q != '1)) pkt_rcvd_q <= pkt_rcvd_q + 1'b1;
      // A push into a full FIFO without a pop means the sender overran its credit.
      if (frame_err || (push && fifo_full && !pop)) err_q <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (push_beat),
    .pop_i   (pop),
    .rdata_o (head_beat),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign out_valid    = ~fifo_empty;
  assign pop          = out_valid & out_ready;
  assign out_sos      = out_valid & head_beat.sos;
  assign out_eos      = out_valid & head_beat.eos;
  assign out_data     = out_valid ? head_beat.FV_data : '0;
  assign beats_stored = fifo_count;
  assign pkt_rcvd     = pkt_rcvd_q;
  assign protocol_err = err_q;
  assign dbg_state_o  = state_q;
  assign RS_available = (state_q == ST_IDLE) && (fifo_count <= CW'(DEPTH - MAX_BEATS));

endmodule

// File: tb/tb_rs_stream_ingress.sv
// Directed bench for rs_stream_ingress with hand-computed expectations.
module tb_rs_stream_ingress;
  import rs_stream_ingress_pkg::*;

  logic                    clk = 1'b0;
  logic                    reset;
  Bank2RS                  rs_pkt_in;
  logic                    RS_available;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_sos;
  logic                    out_eos;
  logic [1:0][FV_size-1:0] out_data;
  logic [4:0]              beats_stored;
  logic [15:0]             pkt_rcvd;
  logic                    protocol_err;
  ingress_state_e          dbg_state_o;

  int n_pass   = 0;
  int n_checks = 0;

  rs_stream_ingress #(.DEPTH(16), .MAX_BEATS(8), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .rs_pkt_in    (rs_pkt_in),
    .RS_available (RS_available),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sos      (out_sos),
    .out_eos      (out_eos),
    .out_data     (out_data),
    .beats_stored (beats_stored),
    .pkt_rcvd     (pkt_rcvd),
    .protocol_err (protocol_err),
    .dbg_state_o  (dbg_state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_beat(input logic s, input logic e, input logic [15:0] w1, input logic [15:0] w0);
    rs_pkt_in.sos        = s;
    rs_pkt_in.eos        = e;
    rs_pkt_in.FV_data[1] = w1;
    rs_pkt_in.FV_data[0] = w0;
  endtask

  task automatic idle_in();
    rs_pkt_in = '0;
  endtask

  function automatic logic [31:0] beat_data(input logic [15:0] w);
    return {w, ~w};
  endfunction

  task automatic send_pkt(input int n, input logic [15:0] base);
    for (int j = 0; j < n; j++) begin
      set_beat(j == 0, j == n - 1, base + 16'(j), ~(base + 16'(j)));
      tick();
    end
    idle_in();
  endtask

  task automatic do_reset();
    idle_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_avail"}, 32'(RS_available), 32'd1);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_sos"},   32'(out_sos), 32'd0);
    chk({tag, "_eos"},   32'(out_eos), 32'd0);
    chk({tag, "_data"},  out_data, 32'd0);
    chk({tag, "_beats"}, 32'(beats_stored), 32'd0);
    chk({tag, "_pkts"},  32'(pkt_rcvd), 32'd0);
    chk({tag, "_err"},   32'(protocol_err), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state_o), 32'(ST_IDLE));
  endtask

  initial begin
    idle_in();
    out_ready = 1'b0;
    reset     = 1'b1;
    do_reset();
    chk_reset_values("rst");

    // One-beat packet with the consumer ready.
    out_ready = 1'b1;
    set_beat(1'b1, 1'b1, 16'h0011, 16'h0022);
    tick();
    idle_in();
    chk("one_valid", 32'(out_valid), 32'd1);
    chk("one_sos",   32'(out_sos), 32'd1);
    chk("one_eos",   32'(out_eos), 32'd1);
    chk("one_data",  out_data, 32'h0011_0022);
    chk("one_pkts",  32'(pkt_rcvd), 32'd1);
    chk("one_avail", 32'(RS_available), 32'd1);
    tick();
    chk("one_drain", 32'(out_valid), 32'd0);
    chk("one_avail2", 32'(RS_available), 32'd1);

    // Three 4-beat packets held in the FIFO.
    out_ready = 1'b0;
    set_beat(1'b1, 1'b0, 16'h0200, ~16'h0200);
    tick();
    chk("p1_avail_recv", 32'(RS_available), 32'd0);
    chk("p1_state_recv", 32'(dbg_state_o), 32'(ST_RECV));
    set_beat(1'b0, 1'b0, 16'h0201, ~16'h0201); tick();
    set_beat(1'b0, 1'b0, 16'h0202, ~16'h0202); tick();
    chk("p1_avail_mid", 32'(RS_available), 32'd0);
    set_beat(1'b0, 1'b1, 16'h0203, ~16'h0203); tick();
    idle_in();
    chk("p1_beats", 32'(beats_stored), 32'd4);
    chk("p1_avail", 32'(RS_available), 32'd1);
    chk("p1_pkts",  32'(pkt_rcvd), 32'd2);
    chk("p1_head_sos", 32'(out_sos), 32'd1);
    chk("p1_head_data", out_data, beat_data(16'h0200));
    send_pkt(4, 16'h0210);
    chk("p2_beats", 32'(beats_stored), 32'd8);
    chk("p2_avail", 32'(RS_available), 32'd1);
    send_pkt(4, 16'h0220);
    chk("p3_beats", 32'(beats_stored), 32'd12);
    chk("p3_avail", 32'(RS_available), 32'd0);
    chk("p3_pkts",  32'(pkt_rcvd), 32'd4);
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    chk("pop4_beats", 32'(beats_stored), 32'd8);
    chk("pop4_avail", 32'(RS_available), 32'd1);
    chk("pop4_head",  out_data, beat_data(16'h0210));
    out_ready = 1'b1;
    repeat (8) tick();
    out_ready = 1'b0;
    chk("drain_beats", 32'(beats_stored), 32'd0);

    // Overlong 10-beat packet: eight kept, the eighth closed with eos.
    send_pkt(10, 16'h0300);
    chk("long_beats", 32'(beats_stored), 32'd8);
    chk("long_err",   32'(protocol_err), 32'd1);
    chk("long_pkts",  32'(pkt_rcvd), 32'd4);
    chk("long_state", 32'(dbg_state_o), 32'(ST_IDLE));
    out_ready = 1'b1;
    repeat (7) tick();
    out_ready = 1'b0;
    chk("long_last_eos",  32'(out_eos), 32'd1);
    chk("long_last_sos",  32'(out_sos), 32'd0);
    chk("long_last_data", out_data, beat_data(16'h0307));
    chk("long_last_cnt",  32'(beats_stored), 32'd1);

    // eos alone while idle.
    do_reset();
    set_beat(1'b0, 1'b1, 16'h0400, 16'h0401);
    tick();
    idle_in();
    chk("eos_alone_err",   32'(protocol_err), 32'd1);
    chk("eos_alone_beats", 32'(beats_stored), 32'd0);
    chk("eos_alone_valid", 32'(out_valid), 32'd0);

    // sos repeated inside a packet.
    do_reset();
    set_beat(1'b1, 1'b0, 16'h0500, ~16'h0500); tick();
    set_beat(1'b1, 1'b0, 16'h0501, ~16'h0501); tick();
    chk("sos_mid_err", 32'(protocol_err), 32'd1);
    set_beat(1'b0, 1'b1, 16'h0502, ~16'h0502); tick();
    idle_in();
    chk("sos_mid_beats", 32'(beats_stored), 32'd3);
    chk("sos_mid_pkts",  32'(pkt_rcvd), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("sos_mid_head_sos",  32'(out_sos), 32'd0);
    chk("sos_mid_head_eos",  32'(out_eos), 32'd0);
    chk("sos_mid_head_data", out_data, beat_data(16'h0501));

    // Full FIFO: simultaneous push/pop, then a push alone.
    do_reset();
    send_pkt(4, 16'h0600);
    send_pkt(4, 16'h0610);
    send_pkt(4, 16'h0620);
    send_pkt(4, 16'h0630);
    chk("full_beats", 32'(beats_stored), 32'd16);
    chk("full_err",   32'(protocol_err), 32'd0);
    chk("full_avail", 32'(RS_available), 32'd0);
    out_ready = 1'b1;
    set_beat(1'b1, 1'b1, 16'h0640, ~16'h0640);
    tick();
    out_ready = 1'b0;
    idle_in();
    chk("pushpop_beats", 32'(beats_stored), 32'd16);
    chk("pushpop_err",   32'(protocol_err), 32'd0);
    chk("pushpop_head",  out_data, beat_data(16'h0601));
    set_beat(1'b1, 1'b1, 16'h0650, ~16'h0650);
    tick();
    idle_in();
    chk("overrun_beats", 32'(beats_stored), 32'd16);
    chk("overrun_err",   32'(protocol_err), 32'd1);

    // Reset after two beats of a five-beat packet.
    do_reset();
    set_beat(1'b1, 1'b0, 16'h0700, ~16'h0700); tick();
    set_beat(1'b0, 1'b0, 16'h0701, ~16'h0701); tick();
    idle_in();
    chk("mid_beats", 32'(beats_stored), 32'd2);
    chk("mid_avail", 32'(RS_available), 32'd0);
    do_reset();
    chk_reset_values("midrst");
    set_beat(1'b0, 1'b0, 16'h0702, ~16'h0702); tick();
    set_beat(1'b0, 1'b0, 16'h0703, ~16'h0703); tick();
    chk("tail_err_pre",   32'(protocol_err), 32'd0);
    chk("tail_beats_pre", 32'(beats_stored), 32'd0);
    set_beat(1'b0, 1'b1, 16'h0704, ~16'h0704); tick();
    idle_in();
    chk("tail_err",   32'(protocol_err), 32'd1);
    chk("tail_beats", 32'(beats_stored), 32'd0);
    chk("tail_valid", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
